// File: rtl/aes256_pkg.sv
// Shared types and constants for the AES-256 host-side controller.
package aes256_pkg;

  localparam int unsigned AES_KEY_W     = 256;
  localparam int unsigned AES_BLK_W     = 128;
  localparam int unsigned AES_BLK_BYTES = 16;

  typedef enum logic [2:0] {
    NOKEY    = 3'd0,
    KEYEXP   = 3'd1,
    READY    = 3'd2,
    LAUNCH   = 3'd3,
    WAITENC  = 3'd4,
    REQ      = 3'd5,
    WAITBYTE = 3'd6,
    OUT      = 3'd7
  } host_state_e;

  // States in which the controller is occupied with the engine.
  function automatic logic is_busy_state(input host_state_e s);
    return !((s == NOKEY) || (s == READY) || (s == OUT));
  endfunction

  // States that wait on an engine response and are guarded by the timeout.
  function automatic logic is_wait_state(input host_state_e s);
    return (s == KEYEXP) || (s == WAITENC) || (s == WAITBYTE);
  endfunction

endpackage

// File: rtl/aes256_byte_collector.sv
// Reassembles the 16 ciphertext bytes (most significant first) into one block.
module aes256_byte_collector
  import aes256_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 shift,
  input  logic [7:0]           byte_in,
  output logic [AES_BLK_W-1:0] data,
  output logic                 last
);

  logic [AES_BLK_W-1:0] shift_d, shift_q;
  logic [3:0]           cnt_d, cnt_q;

  // Next shift-register contents and byte count; clear wins over shift.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear) begin
      shift_d = '0;
      cnt_d   = 4'd0;
    end else if (shift) begin
      shift_d = {shift_q[AES_BLK_W-9:0], byte_in};
      cnt_d   = cnt_q + 4'd1;
    end else begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
    end
  end

  // Collector state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      cnt_q   <= 4'd0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data = shift_q;
  // The byte being shifted while this is high completes the block.
  assign last = (cnt_q == 4'(AES_BLK_BYTES - 1));

endmodule

// File: rtl/aes256_host_ctrl.sv
// Requester-side controller for the AES-256 loading engine: key load,
// block launch, byte-by-byte ciphertext readout and stream hand-off.
module aes256_host_ctrl
  import aes256_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter int unsigned CNT_W          = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_key_load,
  input  logic [AES_KEY_W-1:0] cfg_key,
  output logic                 key_loaded,
  input  logic                 pt_valid,
  output logic                 pt_ready,
  input  logic [AES_BLK_W-1:0] pt_data,
  output logic                 ct_valid,
  input  logic                 ct_ready,
  output logic [AES_BLK_W-1:0] ct_data,
  output logic                 eng_key_expand_start,
  output logic [AES_KEY_W-1:0] eng_master_key,
  input  logic                 eng_key_ready,
  output logic                 eng_next_val_req,
  output logic [AES_BLK_W-1:0] eng_data_in,
  input  logic                 eng_enc_done,
  input  logic                 eng_next_val_ready,
  input  logic [7:0]           eng_data_out,
  output logic                 busy,
  output logic                 timeout_err
);

  host_state_e          state_d, state_q;
  logic [CNT_W-1:0]     tmo_d, tmo_q;
  logic [AES_KEY_W-1:0] key_d, key_q;
  logic [AES_BLK_W-1:0] pt_d, pt_q;
  logic                 key_loaded_d, key_loaded_q;
  logic                 terr_d, terr_q;
  logic                 kstart_q, req_q, pt_ready_q, ct_valid_q, busy_q;
  logic                 kstart_s, clr_s, shift_s, abort_s, last_s, expired_s;

  // The wait has lasted TIMEOUT_CYCLES cycles once the counter would reach it.
  assign expired_s = (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1));

  aes256_byte_collector u_collector (
    .clk     (clk),
    .rst     (rst),
    .clear   (clr_s),
    .shift   (shift_s),
    .byte_in (eng_data_out),
    .data    (ct_data),
    .last    (last_s)
  );

  // Next-state logic; an engine response in the same cycle beats the timeout.
  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    pt_d         = pt_q;
    key_loaded_d = key_loaded_q;
    terr_d       = terr_q;
    kstart_s     = 1'b0;
    clr_s        = 1'b0;
    shift_s      = 1'b0;
    abort_s      = 1'b0;
    case (state_q)
      NOKEY: begin
        if (cfg_key_load) begin
          key_d    = cfg_key;
          kstart_s = 1'b1;
          terr_d   = 1'b0;
          state_d  = KEYEXP;
        end else begin
          state_d = NOKEY;
        end
      end
      KEYEXP: begin
        if (eng_key_ready) begin
          key_loaded_d = 1'b1;
          state_d      = READY;
        end else if (expired_s) begin
          abort_s = 1'b1;
        end else begin
          state_d = KEYEXP;
        end
      end
      READY: begin
        // A plaintext handshake takes priority over a simultaneous key load.
        if (pt_valid && pt_ready_q) begin
          pt_d    = pt_data;
          state_d = LAUNCH;
        end else if (cfg_key_load) begin
          key_loaded_d = 1'b0;
          key_d        = cfg_key;
          kstart_s     = 1'b1;
          terr_d       = 1'b0;
          state_d      = KEYEXP;
        end else begin
          state_d = READY;
        end
      end
      LAUNCH:  state_d = WAITENC;
      WAITENC: begin
        if (eng_enc_done) begin
          clr_s   = 1'b1;
          state_d = REQ;
        end else if (expired_s) begin
          abort_s = 1'b1;
        end else begin
          state_d = WAITENC;
        end
      end
      REQ:     state_d = WAITBYTE;
      WAITBYTE: begin
        if (eng_next_val_ready) begin
          shift_s = 1'b1;
          state_d = last_s ? OUT : REQ;
        end else if (expired_s) begin
          abort_s = 1'b1;
        end else begin
          state_d = WAITBYTE;
        end
      end
      OUT: begin
        if (ct_ready) begin
          state_d = READY;
        end else begin
          state_d = OUT;
        end
      end
      default: state_d = NOKEY;
    endcase
    // Abort drops the key and any partial ciphertext.
    if (abort_s) begin
      terr_d       = 1'b1;
      key_loaded_d = 1'b0;
      clr_s        = 1'b1;
      state_d      = NOKEY;
    end else begin
      terr_d = terr_d;
    end
  end

  // Timeout counter: restarts on every state entry, advances only while waiting.
  always_comb begin
    if (state_d != state_q) begin
      tmo_d = '0;
    end else if (is_wait_state(state_q)) begin
      tmo_d = tmo_q + CNT_W'(1);
    end else begin
      tmo_d = '0;
    end
  end

  // State, data registers and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= NOKEY;
      tmo_q        <= '0;
      key_q        <= '0;
      pt_q         <= '0;
      key_loaded_q <= 1'b0;
      terr_q       <= 1'b0;
      kstart_q     <= 1'b0;
      req_q        <= 1'b0;
      pt_ready_q   <= 1'b0;
      ct_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      key_q        <= key_d;
      pt_q         <= pt_d;
      key_loaded_q <= key_loaded_d;
      terr_q       <= terr_d;
      kstart_q     <= kstart_s;
      req_q        <= (state_d == LAUNCH) || (state_d == REQ);
      pt_ready_q   <= (state_d == READY);
      ct_valid_q   <= (state_d == OUT);
      busy_q       <= is_busy_state(state_d);
    end
  end

  assign key_loaded           = key_loaded_q;
  assign pt_ready             = pt_ready_q;
  assign ct_valid             = ct_valid_q;
  assign eng_key_expand_start = kstart_q;
  assign eng_master_key       = key_q;
  assign eng_next_val_req     = req_q;
  assign eng_data_in          = pt_q;
  assign busy                 = busy_q;
  assign timeout_err          = terr_q;

endmodule

// File: tb/tb_aes256_host_ctrl.sv
// Directed bench for aes256_host_ctrl with a behavioural engine model.
`timescale 1ns/1ps
module tb_aes256_host_ctrl;

  localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY2     = 256'hffeeddccbbaa99887766554433221100_0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [255:0] KEY3     = 256'h13579bdf2468ace0fdb97531eca86420_00000000ffffffff00000000ffffffff;

  logic         clk, rst;
  logic         cfg_key_load, key_loaded, pt_valid, pt_ready, ct_valid, ct_ready;
  logic [255:0] cfg_key, eng_master_key;
  logic [127:0] pt_data, ct_data, eng_data_in;
  logic         eng_key_expand_start, eng_key_ready, eng_next_val_req, eng_enc_done;
  logic         eng_next_val_ready, busy, timeout_err;
  logic [7:0]   eng_data_out;

  int n_vec = 0;
  int n_err = 0;

  // Engine model state and observation counters.
  logic [255:0] e_key;
  logic [127:0] e_ct;
  logic         e_launched;
  int           e_idx, key_cnt, enc_cnt, byte_cnt, req_cnt, exp_cnt, ovl_cnt;
  bit           withhold_enc = 1'b0;
  logic [127:0] ct_q[$];

  aes256_host_ctrl #(.TIMEOUT_CYCLES(1023), .CNT_W(10)) dut (
    .clk(clk), .rst(rst), .cfg_key_load(cfg_key_load), .cfg_key(cfg_key),
    .key_loaded(key_loaded), .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data),
    .eng_key_expand_start(eng_key_expand_start), .eng_master_key(eng_master_key),
    .eng_key_ready(eng_key_ready), .eng_next_val_req(eng_next_val_req),
    .eng_data_in(eng_data_in), .eng_enc_done(eng_enc_done),
    .eng_next_val_ready(eng_next_val_ready), .eng_data_out(eng_data_out),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in cipher: the FIPS-197 AES-256 vector, otherwise a keyed XOR.
  function automatic logic [127:0] eng_model(input logic [255:0] k, input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    return p ^ k[255:128] ^ k[127:0];
  endfunction

  // Engine model (3-cycle latencies) plus ciphertext handshake monitor.
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      eng_key_ready <= 1'b0; eng_enc_done <= 1'b0; eng_next_val_ready <= 1'b0; eng_data_out <= 8'h00;
      e_key <= '0; e_ct <= '0; e_launched <= 1'b0; e_idx <= 0;
      key_cnt <= 0; enc_cnt <= 0; byte_cnt <= 0; req_cnt <= 0; exp_cnt <= 0; ovl_cnt <= 0;
    end else begin
      eng_key_ready      <= (key_cnt == 1);
      eng_enc_done       <= (enc_cnt == 1);
      eng_next_val_ready <= (byte_cnt == 1);
      if (key_cnt != 0) key_cnt <= key_cnt - 1;
      if (enc_cnt != 0) enc_cnt <= enc_cnt - 1;
      if (byte_cnt != 0) byte_cnt <= byte_cnt - 1;
      if (byte_cnt == 1) begin
        eng_data_out <= e_ct[127 - 8*e_idx -: 8];
        if (e_idx == 15) begin e_idx <= 0; e_launched <= 1'b0; end
        else e_idx <= e_idx + 1;
      end
      if (eng_key_expand_start) begin
        exp_cnt <= exp_cnt + 1; e_key <= eng_master_key; key_cnt <= 3;
        e_launched <= 1'b0; e_idx <= 0;
      end
      if (eng_next_val_req) begin
        req_cnt <= req_cnt + 1;
        if (!e_launched) begin
          e_launched <= 1'b1;
          e_ct <= eng_model(e_key, eng_data_in);
          enc_cnt <= withhold_enc ? 0 : 3;
        end else begin
          if (byte_cnt != 0) ovl_cnt <= ovl_cnt + 1;
          byte_cnt <= 3;
        end
      end
      if (ct_valid && ct_ready) ct_q.push_back(ct_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [255:0] k);
    cfg_key = k; cfg_key_load = 1'b1;
    step();
    cfg_key_load = 1'b0;
  endtask

  task automatic wait_key(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (key_loaded) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic send_pt(input logic [127:0] p, output bit ok);
    pt_data = p; pt_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (pt_ready) begin ok = 1'b1; break; end
      step();
    end
    step();
    pt_valid = 1'b0;
  endtask

  task automatic wait_ct(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (ct_q.size() >= n) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; cfg_key_load = 1'b0; cfg_key = '0; pt_valid = 1'b0; pt_data = '0; ct_ready = 1'b0;
    step(); step();
    n_vec++; if ({key_loaded, pt_ready, ct_valid, eng_key_expand_start, eng_next_val_req, busy, timeout_err} !== 7'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b, expected 0000000", {key_loaded, pt_ready, ct_valid, eng_key_expand_start, eng_next_val_req, busy, timeout_err}); end
    n_vec++; if ({ct_data, eng_data_in, eng_master_key} !== 512'b0) begin
      n_err++; $display("FAIL reset_data: got %h %h %h, expected all 0", ct_data, eng_data_in, eng_master_key); end
    rst = 1'b1;
    step();
    n_vec++; if ({pt_ready, key_loaded, busy} !== 3'b000) begin
      n_err++; $display("FAIL nokey_idle: got %b, expected 000", {pt_ready, key_loaded, busy}); end
  endtask

  task automatic test_fips();
    bit ok, kl_ok;
    int r0, o0, n0;
    load_key(FIPS_KEY);
    n_vec++; if (eng_key_expand_start !== 1'b1) begin n_err++; $display("FAIL kstart_pulse: got %b, expected 1", eng_key_expand_start); end
    n_vec++; if (eng_master_key !== FIPS_KEY) begin n_err++; $display("FAIL master_key: got %h, expected %h", eng_master_key, FIPS_KEY); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL busy_keyexp: got %b, expected 1", busy); end
    wait_key(ok);
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL key_loaded_wait: got %b, expected 1", ok); end
    n_vec++; if (pt_ready !== 1'b1) begin n_err++; $display("FAIL pt_ready_ready: got %b, expected 1", pt_ready); end
    r0 = req_cnt; o0 = ovl_cnt; n0 = ct_q.size(); kl_ok = 1'b1;
    ct_ready = 1'b1;
    send_pt(FIPS_PT, ok);
    n_vec++; if (eng_data_in !== FIPS_PT) begin n_err++; $display("FAIL eng_data_in: got %h, expected %h", eng_data_in, FIPS_PT); end
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!key_loaded) kl_ok = 1'b0;
      if (ct_q.size() > n0) begin ok = 1'b1; break; end
      step();
    end
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL fips_ct_arrive: got %b, expected 1", ok); end
    if (ok) begin
      n_vec++; if (ct_q[n0] !== FIPS_CT) begin n_err++; $display("FAIL fips_ct: got %h, expected %h", ct_q[n0], FIPS_CT); end
    end
    n_vec++; if (req_cnt - r0 !== 17) begin n_err++; $display("FAIL req_pulses: got %0d, expected 17", req_cnt - r0); end
    n_vec++; if (kl_ok !== 1'b1) begin n_err++; $display("FAIL key_loaded_hold: got %b, expected 1", kl_ok); end
    n_vec++; if (ovl_cnt - o0 !== 0) begin n_err++; $display("FAIL req_overlap: got %0d, expected 0", ovl_cnt - o0); end
  endtask

  task automatic test_backpressure();
    bit ok, stable;
    int n0;
    logic [127:0] pt, exp_ct;
    pt = 128'h0123456789abcdeffedcba9876543210;
    exp_ct = eng_model(FIPS_KEY, pt);
    ct_ready = 1'b0; n0 = ct_q.size();
    send_pt(pt, ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (ct_valid) begin ok = 1'b1; break; end
      step();
    end
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL bp_ct_valid: got %b, expected 1", ok); end
    n_vec++; if (ct_data !== exp_ct) begin n_err++; $display("FAIL bp_ct_data: got %h, expected %h", ct_data, exp_ct); end
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ct_valid !== 1'b1 || ct_data !== exp_ct || pt_ready !== 1'b0) stable = 1'b0;
    end
    n_vec++; if (stable !== 1'b1) begin n_err++; $display("FAIL bp_hold_stable: got %b, expected 1", stable); end
    n_vec++; if (ct_q.size() !== n0) begin n_err++; $display("FAIL bp_no_accept: got %0d, expected %0d", ct_q.size(), n0); end
    ct_ready = 1'b1;
    step();
    n_vec++; if (pt_ready !== 1'b1) begin n_err++; $display("FAIL bp_pt_ready_after: got %b, expected 1", pt_ready); end
    n_vec++; if (ct_valid !== 1'b0) begin n_err++; $display("FAIL bp_ct_valid_drop: got %b, expected 0", ct_valid); end
    n_vec++; if (ct_q.size() !== n0 + 1) begin n_err++; $display("FAIL bp_one_accept: got %0d, expected %0d", ct_q.size(), n0 + 1); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] pts [3];
    bit ok, all_hs;
    int n0, o0;
    pts[0] = 128'hdeadbeef00000001cafef00d11111111;
    pts[1] = 128'h0f0f0f0ff0f0f0f05a5a5a5aa5a5a5a5;
    pts[2] = 128'hffffffffffffffff0000000000000000;
    n0 = ct_q.size(); o0 = ovl_cnt; all_hs = 1'b1;
    ct_ready = 1'b1; pt_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      pt_data = pts[b]; ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
        if (pt_ready) begin ok = 1'b1; break; end
        step();
      end
      if (!ok) all_hs = 1'b0;
      step();
    end
    pt_valid = 1'b0;
    n_vec++; if (all_hs !== 1'b1) begin n_err++; $display("FAIL b2b_handshakes: got %b, expected 1", all_hs); end
    wait_ct(n0 + 3, ok);
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL b2b_ct_count: got %0d, expected %0d", ct_q.size(), n0 + 3); end
    if (ok) begin
      for (int b = 0; b < 3; b++) begin
        n_vec++; if (ct_q[n0 + b] !== eng_model(FIPS_KEY, pts[b])) begin
          n_err++; $display("FAIL b2b_ct%0d: got %h, expected %h", b, ct_q[n0 + b], eng_model(FIPS_KEY, pts[b])); end
      end
    end
    n_vec++; if (ovl_cnt - o0 !== 0) begin n_err++; $display("FAIL b2b_req_overlap: got %0d, expected 0", ovl_cnt - o0); end
  endtask

  task automatic test_timeout();
    bit ok, cv, idle;
    int n0, k;
    withhold_enc = 1'b1; n0 = ct_q.size(); cv = 1'b0; k = 0;
    send_pt(128'h00000000000000000000000000000abc, ok);
    // One LAUNCH cycle followed by 1023 cycles in WAITENC before the abort edge.
    for (int i = 1; i <= 1100; i++) begin
      step();
      if (ct_valid) cv = 1'b1;
      if (timeout_err) begin k = i; break; end
    end
    n_vec++; if (k !== 1024) begin n_err++; $display("FAIL tmo_cycle: got %0d, expected 1024", k); end
    n_vec++; if (key_loaded !== 1'b0) begin n_err++; $display("FAIL tmo_key_loaded: got %b, expected 0", key_loaded); end
    n_vec++; if (ct_data !== 128'h0) begin n_err++; $display("FAIL tmo_ct_cleared: got %h, expected 0", ct_data); end
    idle = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (ct_valid) cv = 1'b1;
      if (busy !== 1'b0 || pt_ready !== 1'b0 || timeout_err !== 1'b1) idle = 1'b0;
    end
    n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL tmo_nokey_sticky: got %b, expected 1", idle); end
    n_vec++; if (cv !== 1'b0 || ct_q.size() !== n0) begin n_err++; $display("FAIL tmo_no_ct: got %b/%0d, expected 0/%0d", cv, ct_q.size(), n0); end
    withhold_enc = 1'b0;
    load_key(KEY2);
    n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL tmo_err_clear: got %b, expected 0", timeout_err); end
    wait_key(ok);
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL tmo_reload: got %b, expected 1", ok); end
  endtask

  task automatic test_key_load_busy();
    bit ok;
    int n0, e0;
    logic [127:0] pt;
    pt = 128'h6bc1bee22e409f96e93d7e117393172a;
    ct_ready = 1'b1; n0 = ct_q.size(); e0 = exp_cnt;
    send_pt(pt, ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (eng_next_val_req && e_idx >= 3) begin ok = 1'b1; break; end
      step();
    end
    step();
    n_vec++; if ({ok, busy} !== 2'b11) begin n_err++; $display("FAIL kl_busy_reach: got %b, expected 11", {ok, busy}); end
    load_key(KEY3);
    n_vec++; if (eng_key_expand_start !== 1'b0) begin n_err++; $display("FAIL kl_busy_ignored: got %b, expected 0", eng_key_expand_start); end
    wait_ct(n0 + 1, ok);
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL kl_busy_ct_arrive: got %b, expected 1", ok); end
    if (ok) begin
      n_vec++; if (ct_q[n0] !== eng_model(KEY2, pt)) begin n_err++; $display("FAIL kl_busy_ct: got %h, expected %h", ct_q[n0], eng_model(KEY2, pt)); end
    end
    n_vec++; if ({exp_cnt - e0, key_loaded} !== {32'd0, 1'b1}) begin
      n_err++; $display("FAIL kl_busy_state: got %0d/%b, expected 0/1", exp_cnt - e0, key_loaded); end
    n_vec++; if (pt_ready !== 1'b1) begin n_err++; $display("FAIL kl_ready_state: got %b, expected 1", pt_ready); end
    load_key(KEY3);
    n_vec++; if ({key_loaded, eng_key_expand_start} !== 2'b01) begin
      n_err++; $display("FAIL kl_ready_start: got %b, expected 01", {key_loaded, eng_key_expand_start}); end
    n_vec++; if (eng_master_key !== KEY3) begin n_err++; $display("FAIL kl_ready_key: got %h, expected %h", eng_master_key, KEY3); end
    step();
    n_vec++; if (eng_key_expand_start !== 1'b0) begin n_err++; $display("FAIL kl_ready_one_pulse: got %b, expected 0", eng_key_expand_start); end
    wait_key(ok);
    n_vec++; if ({ok, 32'(exp_cnt - e0)} !== {1'b1, 32'd1}) begin
      n_err++; $display("FAIL kl_ready_done: got %b/%0d, expected 1/1", ok, exp_cnt - e0); end
    n0 = ct_q.size();
    send_pt(pt, ok);
    wait_ct(n0 + 1, ok);
    if (ok) begin
      n_vec++; if (ct_q[n0] !== eng_model(KEY3, pt)) begin n_err++; $display("FAIL kl_new_key_ct: got %h, expected %h", ct_q[n0], eng_model(KEY3, pt)); end
    end else begin
      n_vec++; n_err++; $display("FAIL kl_new_key_ct: got no ciphertext, expected one");
    end
  endtask

  task automatic test_reset_mid();
    bit ok, quiet;
    int n0;
    ct_ready = 1'b1; n0 = ct_q.size();
    send_pt(128'h3243f6a8885a308d313198a2e0370734, ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (e_idx == 7) begin ok = 1'b1; break; end
      step();
    end
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL rst_mid_reach: got %b, expected 1", ok); end
    rst = 1'b0;
    #1;
    n_vec++; if ({key_loaded, pt_ready, ct_valid, eng_key_expand_start, eng_next_val_req, busy, timeout_err} !== 7'b0) begin
      n_err++; $display("FAIL rst_mid_ctrl: got %b, expected 0000000", {key_loaded, pt_ready, ct_valid, eng_key_expand_start, eng_next_val_req, busy, timeout_err}); end
    n_vec++; if ({ct_data, eng_data_in, eng_master_key} !== 512'b0) begin
      n_err++; $display("FAIL rst_mid_data: got %h %h %h, expected all 0", ct_data, eng_data_in, eng_master_key); end
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (eng_next_val_req || eng_key_expand_start || ct_valid) quiet = 1'b0;
    end
    n_vec++; if (quiet !== 1'b1) begin n_err++; $display("FAIL rst_mid_quiet: got %b, expected 1", quiet); end
    rst = 1'b1;
    step();
    load_key(FIPS_KEY);
    wait_key(ok);
    n_vec++; if (ct_q.size() !== n0) begin n_err++; $display("FAIL rst_mid_dropped: got %0d, expected %0d", ct_q.size(), n0); end
    send_pt(FIPS_PT, ok);
    wait_ct(n0 + 1, ok);
    if (ok) begin
      n_vec++; if (ct_q[n0] !== FIPS_CT) begin n_err++; $display("FAIL rst_mid_fresh_ct: got %h, expected %h", ct_q[n0], FIPS_CT); end
    end else begin
      n_vec++; n_err++; $display("FAIL rst_mid_fresh_ct: got no ciphertext, expected one");
    end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_backpressure();
    test_back_to_back();
    test_timeout();
    test_key_load_busy();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
